// File: rtl/vga_write_queue.sv
// Posted-write queue for the VGA text/colour RAMs: CPU writes land in a small FIFO
// and drain one per open 4-clk RAM slot, leaving even character-cell halves to scan-out.
module vga_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [9:0]    hx,
  input  logic [9:0]    vy,
  input  logic [15:0]   a,
  input  logic [7:0]    d,
  input  logic          n_we,
  input  logic          ena,
  output logic          n_rdy,
  output logic [AW-1:0] ram_a,
  output logic [7:0]    ram_d,
  output logic          a_sel,
  output logic          n_text_ram_we,
  output logic          n_color_ram_we,
  output logic          n_d_to_text_oe,
  output logic          n_d_to_color_oe,
  output logic          busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 1 + AW + 8;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_TURN   = 3'd4;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [2:0]    state_q, state_d;
  logic          col_q, col_d;
  logic [AW-1:0] ram_a_q, ram_a_d;
  logic [7:0]    ram_d_q, ram_d_d;
  logic          a_sel_q, a_sel_d;
  logic          n_text_we_q, n_text_we_d, n_color_we_q, n_color_we_d;
  logic          n_text_oe_q, n_text_oe_d, n_color_oe_q, n_color_oe_d;
  logic          busy_q, busy_d;

  logic          sel_s, wr_req_s, empty_s, full_s, pop_s, push_s;
  logic          decide_s, active_nxt_s;
  logic [9:0]    hx_nxt_s, vy_nxt_s;
  logic [EW-1:0] entry_s, head_s;

  // Decisions are taken one clock ahead so SETUP lands exactly on the slot boundary.
  always_comb begin
    if (hx == 10'd799) begin
      hx_nxt_s = 10'd0;
      if (vy == 10'd524) begin
        vy_nxt_s = 10'd0;
      end else begin
        vy_nxt_s = vy + 10'd1;
      end
    end else begin
      hx_nxt_s = hx + 10'd1;
      vy_nxt_s = vy;
    end
    active_nxt_s = (hx_nxt_s < 10'd640) && (vy_nxt_s < 10'd480);
    decide_s     = (hx[1:0] == 2'b11) && (!active_nxt_s || hx_nxt_s[2]);
  end

  assign sel_s    = ena & a[15] & a[14] & (a[13] ^ a[12]);
  assign wr_req_s = ~n_we & sel_s;
  assign empty_s  = (count_q == '0);
  assign full_s   = (count_q == CNT_FULL);
  assign entry_s  = {a[12], a[AW-1:0], d};
  // An empty FIFO forwards the incoming write so it can catch the very next slot.
  assign head_s   = empty_s ? entry_s : mem_q[rd_ptr_q];
  assign pop_s    = decide_s & ((state_q == ST_IDLE) | (state_q == ST_TURN)) & (~empty_s | wr_req_s);
  assign push_s   = wr_req_s & (~full_s | pop_s);
  assign n_rdy    = wr_req_s & full_s & ~pop_s;

  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = entry_s;
      wr_ptr_d        = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1'b1);
      2'b01:   count_d = count_q - (PW+1)'(1'b1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_IDLE:   state_d = pop_s ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_TURN;
      ST_TURN:   state_d = pop_s ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (pop_s) begin
      col_d   = head_s[EW-1];
      ram_a_d = head_s[8 +: AW];
      ram_d_d = head_s[7:0];
    end else begin
      col_d   = col_q;
      ram_a_d = ram_a_q;
      ram_d_d = ram_d_q;
    end
    a_sel_d      = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    n_text_we_d  = ~((state_d == ST_STROBE) & ~col_d);
    n_color_we_d = ~((state_d == ST_STROBE) & col_d);
    n_text_oe_d  = ~(a_sel_d & ~col_d);
    n_color_oe_d = ~(a_sel_d & col_d);
    busy_d       = (count_d != '0) || (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= ST_IDLE;
      col_q        <= 1'b0;
      ram_a_q      <= '0;
      ram_d_q      <= 8'd0;
      a_sel_q      <= 1'b0;
      n_text_we_q  <= 1'b1;
      n_color_we_q <= 1'b1;
      n_text_oe_q  <= 1'b1;
      n_color_oe_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      col_q        <= col_d;
      ram_a_q      <= ram_a_d;
      ram_d_q      <= ram_d_d;
      a_sel_q      <= a_sel_d;
      n_text_we_q  <= n_text_we_d;
      n_color_we_q <= n_color_we_d;
      n_text_oe_q  <= n_text_oe_d;
      n_color_oe_q <= n_color_oe_d;
      busy_q       <= busy_d;
    end
  end

  assign ram_a           = ram_a_q;
  assign ram_d           = ram_d_q;
  assign a_sel           = a_sel_q;
  assign n_text_ram_we   = n_text_we_q;
  assign n_color_ram_we  = n_color_we_q;
  assign n_d_to_text_oe  = n_text_oe_q;
  assign n_d_to_color_oe = n_color_oe_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_vga_write_queue.sv
// Scoreboard bench for vga_write_queue: a slot-level model predicts every pop,
// refusal and RAM write; a negedge monitor compares the DUT against it.
module tb_vga_write_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 12;

  typedef struct {
    bit             col;
    logic [AW-1:0]  addr;
    logic [7:0]     data;
    int             scyc;
  } wr_t;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [9:0]    hx, vy;
  logic [15:0]   a;
  logic [7:0]    d;
  logic          n_we, ena;
  logic          n_rdy;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_d;
  logic          a_sel, n_text_ram_we, n_color_ram_we, n_d_to_text_oe, n_d_to_color_oe, busy;

  vga_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .n_rst(n_rst), .hx(hx), .vy(vy), .a(a), .d(d), .n_we(n_we), .ena(ena),
    .n_rdy(n_rdy), .ram_a(ram_a), .ram_d(ram_d), .a_sel(a_sel),
    .n_text_ram_we(n_text_ram_we), .n_color_ram_we(n_color_ram_we),
    .n_d_to_text_oe(n_d_to_text_oe), .n_d_to_color_oe(n_d_to_color_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  int   n_pass = 0, n_total = 0;
  int   cyc = 0, last_pop = -1000, prev_pop = -1000, exp_occ = 0;
  bit   exp_nrdy = 1'b0, refused = 1'b0, mon_en = 1'b0;
  wr_t  mq[$];
  wr_t  sb[$];
  int   strobe_hx[$];
  int   strobe_cyc[$];
  int   cnt_text = 0, cnt_color = 0, cnt_asel = 0, cnt_nrdy = 0;
  logic [9:0] rh = 10'd0, rv = 10'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want)
      $display("FAIL %s: got %0h, want %0h (cycle %0d hx %0d vy %0d)", name, act, want, cyc, hx, vy);
    else
      n_pass++;
  endtask

  // True when the write engine is n..m clocks past one of the two most recent pops.
  function automatic bit hit(input int lo, input int hi);
    return ((cyc - last_pop) >= lo && (cyc - last_pop) <= hi) ||
           ((cyc - prev_pop) >= lo && (cyc - prev_pop) <= hi);
  endfunction

  // A pop happens in the clock just before an open slot boundary.
  function automatic bit open_next(input int h, input int v);
    int nh, nv;
    nh = (h + 1) % 800;
    nv = (h == 799) ? (v + 1) % 525 : v;
    if (nh % 4 != 0) return 1'b0;
    return !(nh < 640 && nv < 480) || (nh % 8 >= 4);
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(9))
      0:       return 16'hC000 | 16'($urandom_range(4095));
      1:       return 16'hF000 | 16'($urandom_range(4095));
      2:       return 16'($urandom);
      3, 4, 5: return 16'hD000 | 16'($urandom_range(4095));
      default: return 16'hE000 | 16'($urandom_range(4095));
    endcase
  endfunction

  task automatic step(input logic [15:0] addr, input logic [7:0] data, input logic we_n, input logic en);
    bit  req, pop, push;
    wr_t e;
    hx = rh; vy = rv; a = addr; d = data; n_we = we_n; ena = en;
    req      = !we_n && en && addr >= 16'hD000 && addr <= 16'hEFFF;
    exp_occ  = mq.size();
    pop      = open_next(int'(rh), int'(rv)) && (exp_occ > 0 || req);
    push     = req && (exp_occ < DEPTH || pop);
    exp_nrdy = req && !push;
    refused  = exp_nrdy;
    if (push) begin
      e.col = (addr[15:12] == 4'hD); e.addr = addr[AW-1:0]; e.data = data; e.scyc = 0;
      mq.push_back(e);
    end
    if (pop) begin
      e = mq.pop_front();
      e.scyc = cyc + 2;
      sb.push_back(e);
      prev_pop = last_pop;
      last_pop = cyc;
    end
    @(posedge clk); #1;
    cyc++;
    rh = (rh == 10'd799) ? 10'd0 : rh + 10'd1;
    if (rh == 10'd0) rv = (rv == 10'd524) ? 10'd0 : rv + 10'd1;
  endtask

  task automatic idle();
    step(16'h0000, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic clear_counts();
    cnt_text = 0; cnt_color = 0; cnt_asel = 0; cnt_nrdy = 0;
  endtask

  task automatic run_random(input int n, input int pct);
    bit          pend;
    logic [15:0] pa;
    logic [7:0]  pd;
    logic        pe;
    pend = 1'b0; pa = 16'h0000; pd = 8'h00; pe = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!pend && $urandom_range(99) < pct) begin
        pend = 1'b1; pa = rand_addr(); pd = 8'($urandom); pe = ($urandom_range(9) != 0);
      end
      if (pend) step(pa, pd, 1'b0, pe);
      else      idle();
      if (pend && !refused) pend = 1'b0;
    end
    repeat (60) idle();
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop on every RAM strobe.
  initial begin
    wr_t e;
    bit  wr_low;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        wr_low = !n_text_ram_we || !n_color_ram_we;
        check("n_rdy", 32'(n_rdy), 32'(exp_nrdy));
        check("a_sel", 32'(a_sel), 32'(hit(1, 3)));
        check("oe_window", 32'(!(n_d_to_text_oe && n_d_to_color_oe)), 32'(hit(1, 3)));
        check("strobe_time", 32'(wr_low), 32'(hit(2, 2)));
        check("busy", 32'(busy), 32'((exp_occ != 0) || hit(1, 4)));
        if (!n_text_ram_we) cnt_text++;
        if (!n_color_ram_we) cnt_color++;
        if (a_sel) cnt_asel++;
        if (n_rdy) cnt_nrdy++;
        if (wr_low) begin
          strobe_hx.push_back(int'(hx));
          strobe_cyc.push_back(cyc);
          check("write_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("wr_addr", 32'(ram_a), 32'(e.addr));
            check("wr_data", 32'(ram_d), 32'(e.data));
            check("wr_ram", 32'({n_text_ram_we, n_color_ram_we}), e.col ? 32'd2 : 32'd1);
            check("wr_oe", 32'({n_d_to_text_oe, n_d_to_color_oe}), e.col ? 32'd2 : 32'd1);
            check("wr_cycle", 32'(cyc), 32'(e.scyc));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    n_rst = 1'b1; hx = 10'd0; vy = 10'd0; a = 16'h0000; d = 8'h00; n_we = 1'b1; ena = 1'b0;
    #1 n_rst = 1'b0;
    #2;
    check("rst_a_sel", 32'(a_sel), 32'd0);
    check("rst_we", 32'({n_text_ram_we, n_color_ram_we}), 32'd3);
    check("rst_oe", 32'({n_d_to_text_oe, n_d_to_color_oe}), 32'd3);
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_ram_d", 32'(ram_d), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_n_rdy", 32'(n_rdy), 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    mon_en = 1'b1;

    // Single text write in horizontal blanking.
    rh = 10'd700; rv = 10'd10; clear_counts();
    step(16'hE123, 8'h41, 1'b0, 1'b1);
    repeat (12) idle();
    check("t1_text_we_clks", 32'(cnt_text), 32'd1);
    check("t1_color_we_clks", 32'(cnt_color), 32'd0);
    check("t1_a_sel_clks", 32'(cnt_asel), 32'd3);
    check("t1_ram_a_held", 32'(ram_a), 32'h123);
    check("t1_ram_d_held", 32'(ram_d), 32'h41);

    // Colour write at the start of an active line waits for the hx=4 slot.
    rh = 10'd0; rv = 10'd20; clear_counts();
    step(16'hD005, 8'h1F, 1'b0, 1'b1);
    repeat (12) idle();
    check("t2_strobe_hx", 32'(strobe_hx[$]), 32'd5);
    check("t2_color_we_clks", 32'(cnt_color), 32'd1);
    check("t2_text_we_clks", 32'(cnt_text), 32'd0);

    // Six back-to-back writes in the active area overflow a 4-deep FIFO.
    rh = 10'd12; rv = 10'd50; clear_counts(); n0 = strobe_cyc.size();
    for (int i = 0; i < 6; i++) begin
      do step(16'hE200 + 16'(i), 8'h30 + 8'(i), 1'b0, 1'b1); while (refused);
    end
    repeat (60) idle();
    check("t3_writes", 32'(strobe_cyc.size() - n0), 32'd6);
    check("t3_nrdy_clks", 32'(cnt_nrdy), 32'd10);
    check("t3_first_hx", 32'(strobe_hx[n0]), 32'd21);
    for (int i = n0 + 1; i < strobe_cyc.size(); i++)
      check("t3_gap", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd8);

    // Pre-filled burst near the end of a line; must finish before the next active line.
    rh = 10'd776; rv = 10'd100; clear_counts(); n0 = strobe_hx.size();
    for (int i = 0; i < 4; i++) begin
      step(16'hE300 + 16'(i), 8'h50 + 8'(i), 1'b0, 1'b1);
      check("t4_accept", 32'(refused), 32'd0);
    end
    repeat (40) idle();
    check("t4_writes", 32'(strobe_hx.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++)
      check("t4_strobe_hx", 32'(strobe_hx[n0 + i]), 32'(781 + 4 * i));

    // Reset asserted while the first of three queued writes is strobing.
    rh = 10'd700; rv = 10'd10; clear_counts();
    for (int i = 0; i < 3; i++) step(16'hE400 + 16'(i), 8'h60 + 8'(i), 1'b0, 1'b1);
    idle(); idle();
    check("t5_in_strobe", 32'(n_text_ram_we), 32'd0);
    mon_en = 1'b0;
    n_rst = 1'b0;
    #1;
    check("t5_rst_we", 32'({n_text_ram_we, n_color_ram_we}), 32'd3);
    check("t5_rst_a_sel", 32'(a_sel), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_oe", 32'({n_d_to_text_oe, n_d_to_color_oe}), 32'd3);
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    mq.delete(); sb.delete();
    last_pop = -1000; prev_pop = -1000; exp_occ = 0; exp_nrdy = 1'b0;
    clear_counts();
    mon_en = 1'b1;
    repeat (30) idle();
    check("t5_no_write_after", 32'(cnt_text + cnt_color), 32'd0);
    check("t5_busy_after", 32'(busy), 32'd0);

    // Addresses outside the window, or with ena low, are ignored.
    clear_counts();
    step(16'hC000, 8'h11, 1'b0, 1'b1); idle();
    step(16'hF000, 8'h22, 1'b0, 1'b1); idle();
    step(16'hE000, 8'h33, 1'b0, 1'b0);
    repeat (10) idle();
    check("t6_nrdy_clks", 32'(cnt_nrdy), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_writes", 32'(cnt_text + cnt_color), 32'd0);

    // Randomised traffic across active area, blanking and frame wrap.
    rh = 10'd600; rv = 10'd478; run_random(3000, 40);
    rh = 10'd700; rv = 10'd523; run_random(2000, 60);
    rh = 10'd100; rv = 10'd200; run_random(1500, 80);
    repeat (40) idle();
    check("drain_scoreboard", 32'(sb.size()), 32'd0);
    check("drain_model", 32'(mq.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
